// File: rtl/fcs_append_pkg.sv
// Shared constants and types for the Ethernet FCS append block and its CRC helper.
// The reflected CRC-32 parameters match the receive-side checker.
package fcs_pkg;

   localparam logic [31:0] CRC_POLY   = 32'hEDB8_8320;
   localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;
   localparam int          FCS_BYTES  = 4;

   typedef enum logic [1:0] {
      IDLE,
      PASS,
      PAD,
      FCS
   } state_t;

   // One registered output beat.
   typedef struct packed {
      logic [7:0] data;
      logic       sof;
      logic       eof;
   } beat_t;

endpackage

// File: rtl/fcs_append_if.sv
// Byte-stream bundle around fcs_append: upstream valid/ready in, downstream valid/ready out.
// The slave modport is the block's view; master is the surrounding environment.
interface fcs_append_if;

   logic       in_valid;
   logic       in_ready;
   logic       start_of_frame;
   logic       end_of_frame;
   logic [7:0] data_in;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] data_out;
   logic       sof_out;
   logic       eof_out;

   modport slave (
      input  in_valid, start_of_frame, end_of_frame, data_in, out_ready,
      output in_ready, out_valid, data_out, sof_out, eof_out
   );

   modport master (
      output in_valid, start_of_frame, end_of_frame, data_in, out_ready,
      input  in_ready, out_valid, data_out, sof_out, eof_out
   );

endinterface

// File: rtl/fcs_append_crc32_next.sv
// Combinational reflected CRC-32 step: one byte, LSB first, no final XOR.
// Also used by the receive-side checker, so it carries no state.
module crc32_next
   import fcs_pkg::*;
(
   input  logic [31:0] i_crc,
   input  logic [7:0]  i_data,
   output logic [31:0] o_crc
);

   logic [31:0] w_c;

   always_comb begin
      w_c = i_crc ^ {24'h0, i_data};
      for (int i = 0; i < 8; i++) begin
         w_c = w_c[0] ? ((w_c >> 1) ^ CRC_POLY) : (w_c >> 1);
      end
      o_crc = w_c;
   end

endmodule

// File: rtl/fcs_append.sv
// Ethernet transmit FCS generator: passes a frame through, optionally zero-pads it to
// MIN_LEN bytes, then appends the 4-byte CRC-32, all behind a single output register.
module fcs_append
   import fcs_pkg::*;
#(
   parameter int PAD_ENABLE = 1,
   parameter int MIN_LEN    = 60,
   parameter int CNT_W      = 11
) (
   input logic         clk,
   input logic         reset,
   fcs_append_if.slave s
);

   localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [1:0]       LAST_IDX = 2'(FCS_BYTES - 1);

   state_t           r_state;
   logic [31:0]      r_crc;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_idx;
   logic             r_out_valid;
   beat_t            r_out;

   logic             w_ld;
   logic             w_in_ready;
   logic             w_acc;
   logic [31:0]      w_crc_in;
   logic [7:0]       w_byte;
   logic [31:0]      w_crc_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [31:0]      w_crc_sh;
   logic [7:0]       w_fcs_byte;
   logic             w_pad_next;
   state_t           w_after_eof;

   // The output register may take a new beat when empty or being drained this cycle.
   assign w_ld       = !r_out_valid || s.out_ready;
   assign w_in_ready = reset && w_ld && ((r_state == IDLE) || (r_state == PASS));
   assign w_acc      = s.in_valid && w_in_ready;

   // In IDLE the first byte always starts from the init value, whatever r_crc holds.
   assign w_crc_in  = (r_state == IDLE) ? CRC_INIT : r_crc;
   assign w_byte    = (r_state == PAD) ? 8'h00 : s.data_in;
   assign w_cnt_nxt = (r_state == IDLE) ? CNT_W'(1)
                    : ((r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1);

   crc32_next u_crc (
      .i_crc  (w_crc_in),
      .i_data (w_byte),
      .o_crc  (w_crc_nxt)
   );

   assign w_crc_sh   = r_crc >> {r_idx, 3'b000};
   assign w_fcs_byte = w_crc_sh[7:0] ^ CRC_XOROUT[7:0];

   // Pad decision is made on the count that includes the eof byte itself.
   assign w_pad_next  = (PAD_ENABLE != 0) && (w_cnt_nxt < MIN_CNT);
   assign w_after_eof = w_pad_next ? PAD : FCS;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_crc       <= CRC_INIT;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_out_valid <= 1'b0;
         r_out       <= '0;
      end else begin
         if (w_ld) begin
            r_out_valid <= 1'b0;
            r_out.sof   <= 1'b0;
            r_out.eof   <= 1'b0;
         end
         unique case (r_state)
            IDLE: begin
               // Beats without sof are dropped here: they belong to no frame.
               if (w_acc && s.start_of_frame) begin
                  r_out_valid <= 1'b1;
                  r_out       <= '{data: s.data_in, sof: 1'b1, eof: 1'b0};
                  r_crc       <= w_crc_nxt;
                  r_cnt       <= w_cnt_nxt;
                  r_idx       <= '0;
                  r_state     <= s.end_of_frame ? w_after_eof : PASS;
               end
            end
            PASS: begin
               if (w_acc) begin
                  r_out_valid <= 1'b1;
                  r_out       <= '{data: s.data_in, sof: 1'b0, eof: 1'b0};
                  r_crc       <= w_crc_nxt;
                  r_cnt       <= w_cnt_nxt;
                  r_idx       <= '0;
                  if (s.end_of_frame) r_state <= w_after_eof;
               end
            end
            PAD: begin
               if (w_ld) begin
                  r_out_valid <= 1'b1;
                  r_out       <= '{data: 8'h00, sof: 1'b0, eof: 1'b0};
                  r_crc       <= w_crc_nxt;
                  r_cnt       <= w_cnt_nxt;
                  if (w_cnt_nxt >= MIN_CNT) r_state <= FCS;
               end
            end
            FCS: begin
               if (w_ld) begin
                  r_out_valid <= 1'b1;
                  r_out       <= '{data: w_fcs_byte, sof: 1'b0, eof: (r_idx == LAST_IDX)};
                  r_idx       <= r_idx + 1'b1;
                  if (r_idx == LAST_IDX) r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign s.in_ready  = w_in_ready;
   assign s.out_valid = r_out_valid;
   assign s.data_out  = r_out.data;
   assign s.sof_out   = r_out.sof;
   assign s.eof_out   = r_out.eof;

endmodule
